// File: rtl/mux_nto1_stream_if.sv
// rtl/mux_nto1_stream_if.sv - handshake bundle between N producers, the mux and one consumer
interface mux_nto1_stream_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    localparam int SEL_W = $clog2(N);

    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_valid;
    logic               out_ready;

    // master: producers plus consumer side (drives inputs, observes outputs)
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_nto1_stream.sv
// rtl/mux_nto1_stream.sv - N:1 stream mux, explicit-select or round-robin, registered output
module mux_nto1_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_nto1_stream_if.slave   bus
);
    localparam int SEL_W = $clog2(N);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,      ptr_d;

    logic             load_en;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;

    assign load_en = !out_valid_q || bus.out_ready;

    // Round-robin scan starts at ptr and wraps mod N; first valid channel wins.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (!bus.mode) begin
            if (32'(bus.sel) < N) begin
                grant_valid = bus.in_valid[bus.sel];
                grant       = bus.sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!grant_valid && bus.in_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant       = idx[SEL_W-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = !rst && load_en && grant_valid && (32'(grant) == i);
        end
    end

    always_comb begin
        int nxt;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        nxt         = int'(grant) + 1;
        if (nxt >= N) nxt = 0;
        if (load_en) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = bus.in_data[int'(grant)*WIDTH +: WIDTH];
                out_ch_d   = grant;
                if (bus.mode) ptr_d = nxt[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb/tb_mux_nto1_stream.sv - directed checks of mux_nto1_stream (N=4 main, N=3 select-range)
module tb_mux_nto1_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mux_nto1_stream_if #(.N(4), .WIDTH(8)) bus4 ();
    mux_nto1_stream_if #(.N(3), .WIDTH(8)) bus3 ();

    mux_nto1_stream #(.WIDTH(8), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_nto1_stream #(.WIDTH(8), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] rr_rdy [5];
        logic [1:0] rr_ch  [5];
        logic [3:0] wr_rdy [3];
        logic [1:0] wr_ch  [3];
        rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        wr_rdy = '{4'b0001, 4'b0100, 4'b0001};
        wr_ch  = '{2'd0, 2'd2, 2'd0};

        bus4.mode = 1'b0; bus4.sel = 2'd0; bus4.in_data = '0;
        bus4.in_valid = 4'b1111; bus4.out_ready = 1'b1;
        bus3.mode = 1'b0; bus3.sel = 2'd3; bus3.in_data = 24'h332211;
        bus3.in_valid = 3'b111; bus3.out_ready = 1'b1;

        // reset state
        step(); step();
        chk("rst_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_data",  32'(bus4.out_data),  32'h00);
        chk("rst_ch",    32'(bus4.out_ch),    32'd0);
        chk("rst_ready", 32'(bus4.in_ready),  32'h0);
        rst = 1'b0;

        // mode 0, sel=2
        bus4.sel = 2'd2; bus4.in_data = {8'h04, 8'hA5, 8'h02, 8'h01};
        bus4.in_valid = 4'b0100;
        #1 chk("m0_ready", 32'(bus4.in_ready), 32'b0100);
        step();
        chk("m0_data",  32'(bus4.out_data),  32'hA5);
        chk("m0_ch",    32'(bus4.out_ch),    32'd2);
        chk("m0_valid", 32'(bus4.out_valid), 32'd1);

        // mode 0, selected channel not valid
        bus4.sel = 2'd1; bus4.in_valid = 4'b1101;
        #1 chk("m0_novalid_ready", 32'(bus4.in_ready), 32'h0);
        step();
        chk("m0_novalid_valid", 32'(bus4.out_valid), 32'd0);
        chk("m0_novalid_hold",  32'(bus4.out_data),  32'hA5);

        // N=3, sel=3 never grants
        for (int c = 0; c < 3; c++) begin
            chk("n3_ready", 32'(bus3.in_ready),  32'h0);
            chk("n3_valid", 32'(bus3.out_valid), 32'd0);
            step();
        end

        // mode 1, all valid, ptr=0: back-to-back rotation
        bus4.mode = 1'b1; bus4.in_valid = 4'b1111;
        bus4.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int c = 0; c < 5; c++) begin
            #1 chk("rr_ready", 32'(bus4.in_ready), 32'(rr_rdy[c]));
            step();
            chk("rr_ch",    32'(bus4.out_ch),    32'(rr_ch[c]));
            chk("rr_data",  32'(bus4.out_data),  32'h10 + 32'(rr_ch[c]));
            chk("rr_valid", 32'(bus4.out_valid), 32'd1);
        end

        // drive ptr to 3 via a ch2 grant, then wrap among channels 0 and 2
        bus4.in_valid = 4'b0100;
        step();
        chk("ptr3_ch", 32'(bus4.out_ch), 32'd2);
        bus4.in_valid = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            #1 chk("wrap_ready", 32'(bus4.in_ready), 32'(wr_rdy[c]));
            step();
            chk("wrap_ch", 32'(bus4.out_ch), 32'(wr_ch[c]));
        end

        // backpressure: hold 8'h3C for 3 cycles
        bus4.mode = 1'b0; bus4.sel = 2'd3; bus4.in_valid = 4'b1000;
        bus4.in_data = {8'h3C, 8'h12, 8'h11, 8'h10};
        step();
        chk("bp_load", 32'(bus4.out_data), 32'h3C);
        bus4.out_ready = 1'b0; bus4.in_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", 32'(bus4.in_ready), 32'h0);
            step();
            chk("bp_data",  32'(bus4.out_data),  32'h3C);
            chk("bp_valid", 32'(bus4.out_valid), 32'd1);
        end
        bus4.out_ready = 1'b1; bus4.sel = 2'd1; bus4.in_valid = 4'b0010;
        bus4.in_data = {8'h3C, 8'h12, 8'h55, 8'h10};
        #1 chk("refill_ready", 32'(bus4.in_ready), 32'b0010);
        step();
        chk("refill_data", 32'(bus4.out_data), 32'h55);
        chk("refill_ch",   32'(bus4.out_ch),   32'd1);

        // ptr currently 1; grant ch1 in mode 1 -> ptr=2, then async reset mid-cycle
        bus4.mode = 1'b1; bus4.in_valid = 4'b0010;
        step();
        chk("pre_rst_valid", 32'(bus4.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", 32'(bus4.out_valid), 32'd0);
        chk("async_data",  32'(bus4.out_data),  32'h00);
        chk("async_ch",    32'(bus4.out_ch),    32'd0);
        chk("async_ready", 32'(bus4.in_ready),  32'h0);
        step();
        rst = 1'b0; bus4.in_valid = 4'b1111;
        #1 chk("post_rst_ready", 32'(bus4.in_ready), 32'b0001);
        step();
        chk("post_rst_ch", 32'(bus4.out_ch), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_nto1_stream.md
Name: mux_nto1_stream

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with a registered output stage and valid/ready handshakes on every port.
- Successor to the fixed 4:1 single-bit combinational mux.
- Two modes: explicit select, or round-robin arbitration among valid channels.
- Sits between several producer streams and one consumer. Sustains one transfer per cycle with 1-cycle latency.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- N, 4, number of input channels (>=2, need not be a power of 2).
- SEL_W, $clog2(N), select/channel-index width (localparam, derived; not overridable).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- mode  input  1  0 = explicit select via sel, 1 = round-robin.
- sel  input  SEL_W  channel to pass in mode 0; ignored in mode 1.
- in_data  input  N*WIDTH  flat bus; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational, at most one bit set.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (asynchronous, immediate, mid-transfer included):
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready=0 while rst is high.
  - Any held output word is discarded.
- Load enable: load_en = !out_valid || out_ready.
  - The output register accepts new data only when load_en=1.
- Grant, mode 0:
  - grant valid iff sel < N and in_valid[sel]; g = sel.
  - sel >= N never grants.
- Grant, mode 1:
  - g = first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap mod N).
  - Grant valid iff any in_valid set.
- in_ready[i] = !rst && load_en && grant_valid && (g == i). in_ready never depends on in_valid[j] for j != g.
- Transfer on a cycle with load_en && grant_valid:
  - out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - In mode 1 only: ptr <= (g+1) mod N, i.e. g=N-1 wraps to 0.
  - In mode 0 ptr is unchanged.
- load_en && !grant_valid: out_valid <= 0; out_data and out_ch hold their last values.
- !load_en (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold; all in_ready=0.
- Latency and throughput:
  - 1 cycle from input handshake to out_valid.
  - Full throughput: one transfer per cycle while out_ready=1 and a grant exists.
- Simultaneous consume and refill: when out_ready=1 and a grant exists in the same cycle, the old word is consumed and the new word loaded with no bubble.
- Mode or sel changes:
  - Take effect combinationally in the same cycle.
  - ptr is preserved across mode switches.
  - No effect on a word already held in the output register.
- Producers must hold in_data/in_valid stable until handshake. The block does not check this.

Test Plan (N=4, WIDTH=8 unless stated):
- Mode 0, sel=2, ch2=8'hA5, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
- Mode 0, sel=1, in_valid=4'b1101 -> in_ready=4'b0000; out_valid=0 after the next edge. With N=3 and sel=3 -> never any grant.
- Mode 1, all in_valid=1, channel i data=8'h10+i, out_ready=1 for 5 cycles -> out_ch=0,1,2,3,0 and out_data=10,11,12,13,10 back-to-back with no bubbles.
- Mode 1, ptr=3, in_valid=4'b0101 -> first grant ch0 (wrap), then ch2, then ch0. Channels 1 and 3 get no in_ready.
- Backpressure: out_valid=1, out_data=8'h3C, out_ready=0 for 3 cycles -> out_data=8'h3C held, in_ready=0 throughout. out_ready=1 -> same-cycle refill from the granted channel.
- Reset mid-operation: out_valid=1, ptr=2, assert rst between edges -> out_valid=0, out_data=0, out_ch=0 immediately; after release, mode 1 with all valid grants ch0 first.
